fpdiv_req_ctrl: RTL
===================

FPDIV_REQ_CTRL -- requirements
Module: fpdiv_req_ctrl

Interface
REQ-001 The block SHALL have parameter LATENCY, default 12, giving the nominal core cycles from core_start to core_done.
REQ-002 The block SHALL have parameter TAG_W, default 4, giving the request/response tag width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request offered.
REQ-006 req_ready  output  1  request accepted when high together with req_valid.
REQ-007 req_op  input  2  divider op code.
REQ-008 req_round_mode  input  1  rounding mode (0 = RNE).
REQ-009 req_dividend, req_divisor  input  32 each  binary32 operands.
REQ-010 req_tag  input  TAG_W  opaque ID returned with the response.
REQ-011 core_start  output  1  one-cycle start pulse to the divider core.
REQ-012 core_op, core_round_mode, core_dividend, core_divisor  output  2/1/32/32  held operands to the core.
REQ-013 core_quotient  input  32  core result, valid when core_done is high.
REQ-014 core_done  input  1  core completion pulse.
REQ-015 rsp_valid  output  1  response buffer non-empty.
REQ-016 rsp_ready  input  1  consumer pops the head entry when high with rsp_valid.
REQ-017 rsp_quotient, rsp_tag, rsp_timeout  output  32/TAG_W/1  head-entry fields.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-020 req_ready SHALL equal (state == IDLE) and (response count < 2), with no same-cycle pop bypass.
REQ-021 On accept, the block SHALL register op, round_mode, dividend, divisor and tag, and go IDLE -> ISSUE.
REQ-022 In ISSUE, core_start SHALL be high for exactly one cycle, then the FSM goes to WAIT with the cycle counter cleared.
REQ-023 core_* operand outputs SHALL stay stable from the cycle after accept until the FSM returns to IDLE.
REQ-024 In WAIT, the counter SHALL increment each cycle.
  - core_done high: push {core_quotient, tag, timeout=0} and return to IDLE.
REQ-025 If the counter reaches LATENCY+4 in WAIT without core_done, the block SHALL:
  - push {32'h7FC00000, tag, timeout=1};
  - return to IDLE.
REQ-026 core_done arriving in IDLE or ISSUE SHALL be ignored.
REQ-027 core_done and timeout in the same cycle SHALL resolve as a normal completion (timeout=0).
REQ-028 The response buffer SHALL be a 2-entry FIFO: write/read pointers wrap modulo 2, plus a 2-bit count.
REQ-029 A simultaneous push and pop SHALL leave the count unchanged and preserve order.
REQ-030 A push SHALL never occur when count == 2; REQ-020 guarantees this, and an assertion SHALL check it.
REQ-031 rsp_* fields SHALL reflect the head entry combinationally; rsp_valid = (count != 0).
REQ-032 Throughput latency SHALL be as follows for accept at cycle 0:
  - core_start at cycle 1;
  - core_done at cycle k gives rsp_valid high at cycle k+1 when the buffer was empty.

Reset
REQ-033 While reset is low, the block SHALL hold:
  - state = IDLE, counter = 0, FIFO pointers and count = 0;
  - core_start = 0, rsp_valid = 0, busy = 0;
  - all held operands and buffer entries = 0.
REQ-034 Reset asserted mid-operation SHALL discard the in-flight request and all buffered responses, with no response for them.
REQ-035 req_ready SHALL become high in the first cycle after reset deasserts.

Verification
REQ-036 Basic: request 3F800000 / 40000000, op=00, tag=3; core model returns 3F000000 after 12 cycles -> one response 3F000000, tag 3, timeout 0, one cycle after core_done.
REQ-037 Backpressure: rsp_ready=0, issue tags 1, 2, 3 -> tags 1 and 2 buffered, req_ready stays low after the second completion; one pop -> tag 3 accepted; responses arrive in order 1, 2, 3.
REQ-038 Timeout: core model never asserts core_done -> 16 cycles after entering WAIT, response 7FC00000 with timeout=1 and matching tag; FSM back in IDLE.
REQ-039 Reset mid-WAIT: reset low at WAIT cycle 5 -> busy=0, rsp_valid=0, core_start=0 immediately; a late core_done produces no response.
REQ-040 Simultaneous push/pop: count=1, rsp_ready=1 in the cycle core_done arrives -> count stays 1 and the new entry becomes head next cycle.
REQ-041 Operand stability: randomize req_* inputs every cycle while busy -> core_* outputs are unchanged from accept until completion.

Source files
------------

// File: rtl/fpdiv_req_ctrl.sv
// ----------------------------------------------------------------------------
// fpdiv_req_ctrl
//
// Request/response front end for a multi-cycle binary32 divider core.
// It accepts one request at a time and holds its operands steady for the
// core. It pulses core_start once, then waits for core_done. If the core
// stays silent for LATENCY+4 cycles, the controller gives up and returns a
// quiet NaN flagged as a timeout. Each completion is pushed into a 2-entry
// response FIFO, and the consumer drains that FIFO with a valid/ready
// handshake.
//
// Ports
//   clk, reset          clock; asynchronous active-low reset
//   req_valid/req_ready request handshake
//   req_op, req_round_mode, req_dividend, req_divisor, req_tag
//                       request payload, captured on accept
//   core_start          one-cycle start pulse to the core
//   core_op, core_round_mode, core_dividend, core_divisor
//                       operands held for the core
//   core_quotient, core_done
//                       core result and its completion pulse
//   rsp_valid/rsp_ready response handshake (FIFO non-empty / pop)
//   rsp_quotient, rsp_tag, rsp_timeout
//                       fields of the FIFO head entry
//   busy                high whenever the FSM is not idle
// ----------------------------------------------------------------------------
module fpdiv_req_ctrl #(
    parameter int LATENCY = 12,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic             req_round_mode,
    input  logic [31:0]      req_dividend,
    input  logic [31:0]      req_divisor,
    input  logic [TAG_W-1:0] req_tag,
    output logic             core_start,
    output logic [1:0]       core_op,
    output logic             core_round_mode,
    output logic [31:0]      core_dividend,
    output logic [31:0]      core_divisor,
    input  logic [31:0]      core_quotient,
    input  logic             core_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_quotient,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_timeout,
    output logic             busy
);

    // The counter must be able to reach LATENCY+4 without wrapping.
    localparam int               CNT_W       = $clog2(LATENCY + 5);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(LATENCY + 4);
    localparam logic [31:0]      QNAN        = 32'h7FC0_0000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             rm_q, rm_d;
    logic [31:0]      dvd_q, dvd_d;
    logic [31:0]      dvs_q, dvs_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic [31:0]      buf_quot_q [2];
    logic [31:0]      buf_quot_d [2];
    logic [TAG_W-1:0] buf_tag_q  [2];
    logic [TAG_W-1:0] buf_tag_d  [2];
    logic             buf_to_q   [2];
    logic             buf_to_d   [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    logic             accept;
    logic             in_wait;
    logic             timeout_hit;
    logic             push;
    logic             pop;
    logic [31:0]      push_quot;
    logic             push_to;

    // Handshakes and the push decision. A core_done in the timeout cycle
    // wins, so a late but real result is never reported as a timeout.
    always_comb begin
        req_ready   = (state_q == ST_IDLE) && (count_q != 2'd2);
        accept      = req_valid && req_ready;
        in_wait     = (state_q == ST_WAIT);
        timeout_hit = in_wait && (cnt_q == TIMEOUT_CNT);
        push        = in_wait && (core_done || timeout_hit);
        push_quot   = core_done ? core_quotient : QNAN;
        push_to     = !core_done;
        pop         = rsp_valid && rsp_ready;
    end

    // Request FSM. Operands are only ever loaded in IDLE, so they stay
    // frozen for the whole ISSUE/WAIT round trip.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rm_d    = rm_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        tag_d   = tag_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = req_op;
                    rm_d    = req_round_mode;
                    dvd_d   = req_dividend;
                    dvs_d   = req_divisor;
                    tag_d   = req_tag;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (push) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Two-entry response FIFO. The pointers toggle, and a push and a pop in
    // the same cycle leave the count unchanged.
    always_comb begin
        buf_quot_d = buf_quot_q;
        buf_tag_d  = buf_tag_q;
        buf_to_d   = buf_to_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            buf_quot_d[wr_ptr_q] = push_quot;
            buf_tag_d[wr_ptr_q]  = tag_q;
            buf_to_d[wr_ptr_q]   = push_to;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            op_q          <= '0;
            rm_q          <= 1'b0;
            dvd_q         <= '0;
            dvs_q         <= '0;
            tag_q         <= '0;
            buf_quot_q[0] <= '0;
            buf_quot_q[1] <= '0;
            buf_tag_q[0]  <= '0;
            buf_tag_q[1]  <= '0;
            buf_to_q[0]   <= 1'b0;
            buf_to_q[1]   <= 1'b0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            rm_q       <= rm_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            tag_q      <= tag_d;
            buf_quot_q <= buf_quot_d;
            buf_tag_q  <= buf_tag_d;
            buf_to_q   <= buf_to_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        core_start      = (state_q == ST_ISSUE);
        busy            = (state_q != ST_IDLE);
        core_op         = op_q;
        core_round_mode = rm_q;
        core_dividend   = dvd_q;
        core_divisor    = dvs_q;
        rsp_valid       = (count_q != 2'd0);
        rsp_quotient    = buf_quot_q[rd_ptr_q];
        rsp_tag         = buf_tag_q[rd_ptr_q];
        rsp_timeout     = buf_to_q[rd_ptr_q];
    end

    // req_ready is gated on a non-full FIFO, so a push into a full FIFO
    // would mean the gating is broken.
    assert property (@(posedge clk) disable iff (!reset) !(push && (count_q == 2'd2)));

endmodule
